pin_shift_bridge: RTL

Parametrised pin-limited I/O bridge for synthesis tops: deserialises a multi-lane input pin bus into a wide word for the core, and serialises core result words onto a multi-lane output pin bus. This generation of the top-level shift logic adds several capabilities:
- configurable lane count and word widths;
- explicit framing with pause and resync;
- a result FIFO, so back-to-back core results are never overwritten mid-shift;
- a sticky overflow flag.

---
 rtl/pin_shift_bridge.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/pin_shift_bridge.sv
// Pin-limited I/O bridge: deserialises LANES-wide input beats into IN_BITS words and
// serialises queued OUT_BITS results onto LANES output pins, MSB lanes first.
module pin_shift_bridge #(
  parameter int unsigned IN_BITS    = 64,
  parameter int unsigned OUT_BITS   = 64,
  parameter int unsigned LANES      = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_en_p,
  input  logic                in_sync_p,
  input  logic [LANES-1:0]    in_lanes_p,
  output logic [IN_BITS-1:0]  in_data,
  output logic                in_valid,
  input  logic                res_valid,
  input  logic [OUT_BITS-1:0] res_data,
  output logic                out_frame_p,
  output logic [LANES-1:0]    out_lanes_p,
  output logic                ovf_p
);

  localparam int unsigned BEATS_IN  = (IN_BITS + LANES - 1) / LANES;
  localparam int unsigned BEATS_OUT = (OUT_BITS + LANES - 1) / LANES;
  localparam int unsigned SR_IN_W   = BEATS_IN * LANES;
  localparam int unsigned SR_OUT_W  = BEATS_OUT * LANES;
  localparam int unsigned ICNT_W    = (BEATS_IN > 1) ? $clog2(BEATS_IN) : 1;
  localparam int unsigned OCNT_W    = (BEATS_OUT > 1) ? $clog2(BEATS_OUT) : 1;
  localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH);

  localparam logic [ICNT_W-1:0] ICNT_LAST = ICNT_W'(BEATS_IN - 1);
  localparam logic [OCNT_W-1:0] OCNT_LAST = OCNT_W'(BEATS_OUT - 1);
  localparam logic [PTR_W:0]    FIFO_FULL = (PTR_W + 1)'(FIFO_DEPTH);

  // ---------------------------------------------------------------- input path
  logic               en_q;
  logic               sync_q;
  logic [LANES-1:0]   lanes_q;
  logic [SR_IN_W-1:0] isr_q;
  logic [SR_IN_W-1:0] isr_shift;
  logic [ICNT_W-1:0]  icnt_q;

  always_comb begin
    isr_shift = (isr_q << LANES) | SR_IN_W'(lanes_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      en_q     <= 1'b0;
      sync_q   <= 1'b0;
      lanes_q  <= '0;
      isr_q    <= '0;
      icnt_q   <= '0;
      in_data  <= '0;
      in_valid <= 1'b0;
    end else begin
      en_q     <= in_en_p;
      sync_q   <= in_sync_p;
      lanes_q  <= in_lanes_p;
      in_valid <= 1'b0;
      // Resync wins over a coincident enable: that beat's data is dropped.
      if (sync_q) begin
        icnt_q <= '0;
        isr_q  <= '0;
      end else if (en_q) begin
        isr_q <= isr_shift;
        if (icnt_q == ICNT_LAST) begin
          icnt_q   <= '0;
          in_data  <= isr_shift[IN_BITS-1:0];
          in_valid <= 1'b1;
        end else begin
          icnt_q <= icnt_q + ICNT_W'(1);
        end
      end
    end
  end

  // --------------------------------------------------------------- output path
  typedef enum logic [0:0] {StIdle, StShift} ser_state_e;

  ser_state_e          state_q, state_d;
  logic [OUT_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]    wptr_q, rptr_q;
  logic [PTR_W:0]      count_q;
  logic [SR_OUT_W-1:0] osr_q;
  logic [SR_OUT_W-1:0] head_ext;
  logic [OCNT_W-1:0]   ocnt_q;
  logic                full, empty, push, pop;

  assign full  = (count_q == FIFO_FULL);
  assign empty = (count_q == '0);
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign push  = res_valid && (!full || pop);

  always_comb begin
    head_ext                 = '0;
    head_ext[OUT_BITS-1:0]   = mem_q[rptr_q];
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = StShift;
        end
      end
      StShift: begin
        if (ocnt_q == OCNT_LAST) begin
          if (!empty) begin
            pop = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q] <= res_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      osr_q       <= '0;
      ocnt_q      <= '0;
      out_frame_p <= 1'b0;
      out_lanes_p <= '0;
      ovf_p       <= 1'b0;
    end else begin
      state_q <= state_d;
      if (push) wptr_q <= wptr_q + PTR_W'(1);
      if (pop)  rptr_q <= rptr_q + PTR_W'(1);
      if (push && !pop) begin
        count_q <= count_q + (PTR_W + 1)'(1);
      end else if (pop && !push) begin
        count_q <= count_q - (PTR_W + 1)'(1);
      end
      if (res_valid && !push) ovf_p <= 1'b1;

      out_frame_p <= (state_q == StShift);
      out_lanes_p <= (state_q == StShift) ? osr_q[SR_OUT_W-1 -: LANES] : '0;

      if (pop) begin
        osr_q  <= head_ext;
        ocnt_q <= '0;
      end else if (state_q == StShift) begin
        osr_q  <= osr_q << LANES;
        ocnt_q <= ocnt_q + OCNT_W'(1);
      end
    end
  end

endmodule
